// File: rtl/click_pkg.sv
// Shared defaults and helpers for the two-phase click pipeline.
package click_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;

  // Bits needed to represent an occupancy of 0..depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/click_stage.sv
// One click stage: a phase bit, a data register and the fire term that advances them.
module click_stage
  import click_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic             phase,
  output logic [WIDTH-1:0] data,
  output logic             fire,
  output logic             full
);

  // Empty (phase matches successor) and a new token offered (phase differs from predecessor).
  assign fire = (phase == ack) && (phase != req);
  assign full = (phase != ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= 1'b0;
      data  <= '0;
    end else if (fire) begin
      phase <= ~phase;
      data  <= din;
    end
  end

endmodule

// File: rtl/click_pipeline.sv
// Two-phase bundled-data click pipeline, modelled synchronously, with occupancy
// and a saturating delivered-token counter.
module click_pipeline
  import click_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_req,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ack,
  output logic                        out_req,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ack,
  output logic [DEPTH-1:0]            fire,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  input  logic                        clr_count,
  output logic [CNT_W-1:0]            tok_count
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] s;
  logic [DEPTH-1:0] full;
  logic [DEPTH-1:0] req_w;
  logic [DEPTH-1:0] ack_w;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] din_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign req_w[i] = in_req;
      assign din_w[i] = in_data;
    end else begin : g_body
      assign req_w[i] = s[i-1];
      assign din_w[i] = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign ack_w[i] = out_ack;
    end else begin : g_link
      assign ack_w[i] = s[i+1];
      // A stage can only fire into an empty slot, so a full stage never fires into a full successor.
      assert property (@(posedge clk) disable iff (!rst_n)
                       !(fire[i] && full[i] && full[i+1]));
    end

    click_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_w[i]),
      .ack   (ack_w[i]),
      .din   (din_w[i]),
      .phase (s[i]),
      .data  (d[i]),
      .fire  (fire[i]),
      .full  (full[i])
    );
  end

  assign in_ack   = s[0];
  assign out_req  = s[DEPTH-1];
  assign out_data = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(full[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok_count <= '0;
    end else if (clr_count) begin
      tok_count <= '0;
    end else if (fire[DEPTH-1] && (tok_count != {CNT_W{1'b1}})) begin
      tok_count <= tok_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_click_pipeline.sv
// Directed bench for click_pipeline (WIDTH=8, DEPTH=4, CNT_W=4).
module tb_click_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_req;
  logic [7:0] in_data;
  logic       in_ack;
  logic       out_req;
  logic [7:0] out_data;
  logic       out_ack;
  logic [3:0] fire;
  logic [2:0] occupancy;
  logic       clr_count;
  logic [3:0] tok_count;

  int n_cmp = 0;
  int n_bad = 0;

  click_pipeline #(
    .WIDTH(8),
    .DEPTH(4),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .fire      (fire),
    .occupancy (occupancy),
    .clr_count (clr_count),
    .tok_count (tok_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_req = 1'b0; out_ack = 1'b0; clr_count = 1'b0; in_data = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_req = 1'b0; out_ack = 1'b0; clr_count = 1'b0; in_data = 8'hFF;
    tick();
    tick();
    n_cmp++; if (in_ack !== 1'b0) begin n_bad++; $display("FAIL rst_in_ack got=%b exp=0", in_ack); end
    n_cmp++; if (out_req !== 1'b0) begin n_bad++; $display("FAIL rst_out_req got=%b exp=0", out_req); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (fire !== 4'b0000) begin n_bad++; $display("FAIL rst_fire got=%b exp=0000", fire); end
    n_cmp++; if (tok_count !== 4'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", tok_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    in_data = 8'hA5;
    in_req  = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) begin
        n_cmp++; if (in_ack !== 1'b1) begin n_bad++; $display("FAIL lat_in_ack got=%b exp=1", in_ack); end
      end
      n_cmp++;
      if (out_req !== (e == 4)) begin
        n_bad++; $display("FAIL lat_out_req edge=%0d got=%b exp=%b", e, out_req, (e == 4));
      end
      n_cmp++;
      if (occupancy !== 3'd1) begin
        n_bad++; $display("FAIL lat_occ edge=%0d got=%0d exp=1", e, occupancy);
      end
    end
    n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL lat_out_data got=%h exp=a5", out_data); end
    out_ack = 1'b1;
    tick();
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL lat_occ_drain got=%0d exp=0", occupancy); end
    n_cmp++; if (tok_count !== 4'd1) begin n_bad++; $display("FAIL lat_count got=%0d exp=1", tok_count); end
  endtask

  task automatic test_backpressure();
    int acc;
    int c;
    do_reset();
    acc = 0;
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      in_req  = ~in_req;
      for (c = 0; c < 20 && in_ack !== in_req; c++) tick();
      if (in_ack === in_req) acc++;
    end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    in_data = 8'h05;
    in_req  = ~in_req;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (in_ack !== 1'b0) begin n_bad++; $display("FAIL bp_pending in_ack got=%b exp=0", in_ack); end
    n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occ got=%0d exp=4", occupancy); end
    for (int k = 1; k <= 5; k++) begin
      for (c = 0; c < 20 && out_req === out_ack; c++) tick();
      n_cmp++;
      if (out_req === out_ack) begin
        n_bad++; $display("FAIL bp_drain_timeout token=%0d got=none exp=%h", k, 8'(k));
      end else if (out_data !== 8'(k)) begin
        n_bad++; $display("FAIL bp_drain_data token=%0d got=%h exp=%h", k, out_data, 8'(k));
      end
      out_ack = ~out_ack;
      tick();
    end
    n_cmp++; if (in_ack !== in_req) begin n_bad++; $display("FAIL bp_fifth_ack got=%b exp=%b", in_ack, in_req); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL bp_occ_end got=%0d exp=0", occupancy); end
    n_cmp++; if (tok_count !== 4'd5) begin n_bad++; $display("FAIL bp_count got=%0d exp=5", tok_count); end
  endtask

  task automatic test_streaming();
    int tx, rx, last;
    do_reset();
    in_data = 8'h10;
    in_req  = ~in_req;
    tx = 1; rx = 0; last = 0;
    for (int c = 1; c <= 80 && rx < 10; c++) begin
      tick();
      if (out_req !== out_ack) begin
        n_cmp++;
        if (out_data !== 8'(8'h10 + rx)) begin
          n_bad++; $display("FAIL stream_data idx=%0d got=%h exp=%h", rx, out_data, 8'(8'h10 + rx));
        end
        n_cmp++;
        if (rx == 0) begin
          if (c != 4) begin n_bad++; $display("FAIL stream_first_edge got=%0d exp=4", c); end
        end else if (c - last != 2) begin
          n_bad++; $display("FAIL stream_interval idx=%0d got=%0d exp=2", rx, c - last);
        end
        last = c;
        rx++;
        out_ack = out_req;
      end
      if (in_ack === in_req && tx < 10) begin
        in_data = 8'(8'h10 + tx);
        in_req  = ~in_req;
        tx++;
      end
    end
    n_cmp++; if (rx != 10) begin n_bad++; $display("FAIL stream_received got=%0d exp=10", rx); end
    tick();
    n_cmp++; if (tok_count !== 4'd10) begin n_bad++; $display("FAIL stream_count got=%0d exp=10", tok_count); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL stream_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_saturation();
    int tx, rx, c;
    do_reset();
    tx = 0; rx = 0;
    for (c = 0; c < 200 && rx < 20; c++) begin
      if (in_ack === in_req && tx < 20) begin
        in_data = 8'(tx);
        in_req  = ~in_req;
        tx++;
      end
      tick();
      if (out_req !== out_ack) begin
        rx++;
        out_ack = out_req;
      end
    end
    tick();
    tick();
    n_cmp++; if (rx != 20) begin n_bad++; $display("FAIL sat_received got=%0d exp=20", rx); end
    n_cmp++; if (tok_count !== 4'd15) begin n_bad++; $display("FAIL sat_count got=%0d exp=15", tok_count); end
    in_data = 8'h77;
    in_req  = ~in_req;
    for (c = 0; c < 20 && fire[3] !== 1'b1; c++) tick();
    n_cmp++; if (fire[3] !== 1'b1) begin n_bad++; $display("FAIL sat_fire_timeout got=%b exp=1", fire[3]); end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_cmp++; if (tok_count !== 4'd0) begin n_bad++; $display("FAIL sat_clear_priority got=%0d exp=0", tok_count); end
    n_cmp++; if (out_data !== 8'h77) begin n_bad++; $display("FAIL sat_clear_data got=%h exp=77", out_data); end
    out_ack = out_req;
    tick();
    in_data = 8'h78;
    in_req  = ~in_req;
    for (c = 0; c < 20 && out_req === out_ack; c++) tick();
    out_ack = out_req;
    tick();
    n_cmp++; if (tok_count !== 4'd1) begin n_bad++; $display("FAIL sat_recount got=%0d exp=1", tok_count); end
  endtask

  task automatic test_reset_midop();
    int c;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'hC0 + k);
      in_req  = ~in_req;
      for (c = 0; c < 20 && in_ack !== in_req; c++) tick();
    end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL mid_occ_before got=%0d exp=3", occupancy); end
    rst_n = 1'b0; in_req = 1'b0; out_ack = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (out_req !== 1'b0) begin n_bad++; $display("FAIL mid_out_req got=%b exp=0", out_req); end
    n_cmp++; if (tok_count !== 4'd0) begin n_bad++; $display("FAIL mid_count got=%0d exp=0", tok_count); end
    n_cmp++; if (in_ack !== 1'b0) begin n_bad++; $display("FAIL mid_in_ack got=%b exp=0", in_ack); end
    rst_n = 1'b1;
    tick();
    in_data = 8'h5A;
    in_req  = 1'b1;
    for (c = 1; c <= 20; c++) begin
      tick();
      if (out_req === 1'b1) break;
    end
    n_cmp++; if (c != 4) begin n_bad++; $display("FAIL mid_latency got=%0d exp=4", c); end
    n_cmp++; if (out_data !== 8'h5A) begin n_bad++; $display("FAIL mid_data got=%h exp=5a", out_data); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_streaming();
    test_saturation();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/click_pipeline.md
CLICK_PIPELINE -- requirements
Module: click_pipeline

Interface
- REQ-001 Parameter WIDTH, default 8: data bits per token.
- REQ-002 Parameter DEPTH, default 4: number of click stages; legal range 2..16.
- REQ-003 Parameter CNT_W, default 16: width of the delivered-token counter.
- REQ-004 clk  input  1  clock; all state changes on rising edge.
- REQ-005 rst_n  input  1  reset, synchronous, active-low.
- REQ-006 in_req  input  1  upstream two-phase request; each toggle is a new token; synchronous to clk.
- REQ-007 in_data  input  WIDTH  upstream data; stable from in_req toggle until in_ack matches.
- REQ-008 in_ack  output  1  upstream two-phase acknowledge.
- REQ-009 out_req  output  1  downstream two-phase request.
- REQ-010 out_data  output  WIDTH  downstream data, valid while out_req != out_ack.
- REQ-011 out_ack  input  1  downstream two-phase acknowledge; synchronous to clk.
- REQ-012 fire  output  DEPTH  per-stage fire strobe, combinational from registered state.
- REQ-013 occupancy  output  $clog2(DEPTH+1)  number of full stages.
- REQ-014 clr_count  input  1  synchronous clear of tok_count.
- REQ-015 tok_count  output  CNT_W  saturating count of tokens delivered downstream.

Function
- REQ-016 Stage i SHALL hold phase bit s[i] and data register d[i]; req_i = in_req for i=0, else s[i-1]; ack_i = out_ack for i=DEPTH-1, else s[i+1].
- REQ-017 fire[i] SHALL be (s[i]==ack_i) & (s[i]!=req_i).
- REQ-018 On a rising edge with fire[i]=1, s[i] SHALL toggle and d[i] SHALL load in_data (i=0) or d[i-1]; otherwise both hold.
- REQ-019 All stages SHALL evaluate from pre-edge values, so a token advances at most one stage per cycle.
- REQ-020 in_ack SHALL equal s[0]; out_req SHALL equal s[DEPTH-1]; out_data SHALL equal d[DEPTH-1].
- REQ-021 Stage i is full when s[i] != ack_i; occupancy SHALL equal the count of full stages.
- REQ-022 Latency: for an empty pipeline, in_req toggle sampled at edge 1 SHALL produce an out_req toggle at edge DEPTH.
- REQ-023 Steady-state throughput with out_ack answering in the same cycle SHALL be one token per 2 cycles.
- REQ-024 When all DEPTH stages are full, in_ack SHALL hold and further in_req toggles SHALL remain pending without data loss.
- REQ-025 tok_count SHALL increment on each edge where fire[DEPTH-1]=1 and SHALL saturate at 2^CNT_W-1.
- REQ-026 clr_count=1 SHALL set tok_count to 0 on the next edge and SHALL take priority over a simultaneous increment.
- REQ-027 Simultaneous input token and output acknowledge SHALL both be processed in the same cycle.

Reset
- REQ-028 With rst_n=0 at an edge, all s[i], d[i], and tok_count SHALL become 0; in_ack=0, out_req=0, out_data=0, occupancy=0, fire=0 when in_req=0.
- REQ-029 Reset mid-operation SHALL discard all in-flight tokens; the environment re-initialises in_req and out_ack to 0.

Structure
- REQ-030 Package click_pkg SHALL hold default WIDTH, DEPTH, and CNT_W constants, plus an occupancy-width function.
- REQ-031 A sub-module click_stage SHALL implement one phase bit, one data register, and its fire term; click_pipeline SHALL instantiate DEPTH of them with a generate loop.

Verification
- REQ-032 DEPTH=4: reset, then toggle in_req 0->1 with in_data=0xA5 -> in_ack=1 after edge 1; out_req=1 with out_data=0xA5 after edge 4; occupancy=1 from edge 1 until out_ack toggles.
- REQ-033 Backpressure: out_ack held at 0, offer 5 tokens 0x01..0x05 -> in_ack toggles 4 times; occupancy=4; 5th token pending; then out_ack handshakes deliver 0x01..0x05 in order.
- REQ-034 Streaming: 10 tokens, with out_ack mirroring out_req each cycle -> out_req toggles every 2 cycles; tok_count=10; data in order.
- REQ-035 Saturation: CNT_W=4, deliver 20 tokens -> tok_count=15; assert clr_count during a delivery -> tok_count=0.
- REQ-036 Reset mid-operation with occupancy=3 -> after the reset edge, occupancy=0, out_req=0, tok_count=0; a new token then traverses in DEPTH cycles.
- REQ-037 Assertion: fire[i] SHALL never be 1 while stage i is full and its successor is full.
